// File: rtl/placar_acumulador.sv
// Registered multi-team score accumulator with edge-detected command buttons,
// underflow blocking, saturating addition and a single-entry undo history.
module placar_acumulador #(
    parameter int LARGURA    = 7,
    parameter int MAX_PONTOS = 99,
    parameter int N_EQUIPES  = 2,
    parameter int SEL_W      = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           botao,
    input  logic                           desfazer,
    input  logic                           zerar,
    input  logic [SEL_W-1:0]               equipe,
    input  logic [1:0]                     pontos,
    input  logic                           chavePN,
    output logic [N_EQUIPES*LARGURA-1:0]   placar,
    output logic                           erro_sub,
    output logic                           saturou,
    output logic                           desfazer_ok
);

    logic                botao_q_r;
    logic                desfazer_q_r;
    logic [LARGURA-1:0]  scores_r [N_EQUIPES];
    logic [SEL_W-1:0]    hist_eq_r;
    logic [LARGURA-1:0]  hist_score_r;
    logic                hist_valid_r;
    logic                erro_sub_r;
    logic                saturou_r;

    logic                ev_b_s;
    logic                ev_u_s;
    logic                sel_ok_s;
    logic [LARGURA-1:0]  cur_score_s;
    logic [LARGURA:0]    sum_s;
    logic                sum_over_s;
    logic [LARGURA-1:0]  add_res_s;
    logic                sub_ok_s;
    logic                cmd_s;

    // Event detection and arithmetic on the currently selected team.
    always_comb begin
        ev_b_s      = botao & ~botao_q_r;
        ev_u_s      = desfazer & ~desfazer_q_r;
        sel_ok_s    = (32'(equipe) < N_EQUIPES);
        cur_score_s = '0;
        for (int k = 0; k < N_EQUIPES; k++) begin
            cur_score_s = (SEL_W'(k) == equipe) ? scores_r[k] : cur_score_s;
        end
        sum_s      = (LARGURA+1)'(cur_score_s) + (LARGURA+1)'(pontos);
        sum_over_s = (sum_s > (LARGURA+1)'(MAX_PONTOS));
        if (sum_over_s) begin
            add_res_s = LARGURA'(MAX_PONTOS);
        end else begin
            add_res_s = sum_s[LARGURA-1:0];
        end
        sub_ok_s = (cur_score_s >= LARGURA'(pontos));
        cmd_s    = ev_b_s & (pontos != 2'd0) & sel_ok_s;
    end

    // Button history flops; reset high so a button held through reset release is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            botao_q_r    <= 1'b1;
            desfazer_q_r <= 1'b1;
        end else begin
            botao_q_r    <= botao;
            desfazer_q_r <= desfazer;
        end
    end

    // Score, history and flag update with priority zerar > undo > command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_EQUIPES; k++) begin
                scores_r[k] <= '0;
            end
            hist_eq_r    <= '0;
            hist_score_r <= '0;
            hist_valid_r <= 1'b0;
            erro_sub_r   <= 1'b0;
            saturou_r    <= 1'b0;
        end else begin
            erro_sub_r <= 1'b0;
            saturou_r  <= 1'b0;
            if (zerar) begin
                for (int k = 0; k < N_EQUIPES; k++) begin
                    scores_r[k] <= '0;
                end
                hist_valid_r <= 1'b0;
            end else if (ev_u_s) begin
                if (hist_valid_r) begin
                    for (int k = 0; k < N_EQUIPES; k++) begin
                        if (SEL_W'(k) == hist_eq_r) begin
                            scores_r[k] <= hist_score_r;
                        end
                    end
                    hist_valid_r <= 1'b0;
                end
            end else if (cmd_s) begin
                if (!chavePN) begin
                    for (int k = 0; k < N_EQUIPES; k++) begin
                        if (SEL_W'(k) == equipe) begin
                            scores_r[k] <= add_res_s;
                        end
                    end
                    saturou_r    <= sum_over_s;
                    hist_eq_r    <= equipe;
                    hist_score_r <= cur_score_s;
                    hist_valid_r <= 1'b1;
                end else if (sub_ok_s) begin
                    for (int k = 0; k < N_EQUIPES; k++) begin
                        if (SEL_W'(k) == equipe) begin
                            scores_r[k] <= cur_score_s - LARGURA'(pontos);
                        end
                    end
                    hist_eq_r    <= equipe;
                    hist_score_r <= cur_score_s;
                    hist_valid_r <= 1'b1;
                end else begin
                    erro_sub_r <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        placar = '0;
        for (int k = 0; k < N_EQUIPES; k++) begin
            placar[k*LARGURA +: LARGURA] = scores_r[k];
        end
    end

    assign erro_sub    = erro_sub_r;
    assign saturou     = saturou_r;
    assign desfazer_ok = hist_valid_r;

endmodule

// File: tb/tb_placar_acumulador.sv
// Bench for placar_acumulador: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against an integer score model.
module tb_placar_acumulador;

    localparam int LARGURA = 7;
    localparam int MAXP    = 99;

    logic        clk;
    logic        rst_n;
    logic        botao;
    logic        desfazer;
    logic        zerar;
    logic [0:0]  equipe;
    logic [1:0]  pontos;
    logic        chavePN;
    logic [13:0] placar;
    logic        erro_sub;
    logic        saturou;
    logic        desfazer_ok;

    int total;
    int bad;

    placar_acumulador dut (
        .clk(clk), .rst_n(rst_n), .botao(botao), .desfazer(desfazer),
        .zerar(zerar), .equipe(equipe), .pontos(pontos), .chavePN(chavePN),
        .placar(placar), .erro_sub(erro_sub), .saturou(saturou),
        .desfazer_ok(desfazer_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain integer scores and a one-deep undo record.
    int m_score [2];
    int m_heq;
    int m_hs;
    bit m_hv;
    bit m_pb;
    bit m_pu;
    bit m_err;
    bit m_sat;

    always @(posedge clk or negedge rst_n) begin
        bit eb;
        bit eu;
        int s;
        int p;
        if (!rst_n) begin
            m_score[0] = 0; m_score[1] = 0;
            m_hv = 1'b0; m_pb = 1'b1; m_pu = 1'b1;
            m_err = 1'b0; m_sat = 1'b0;
            m_heq = 0; m_hs = 0;
        end else begin
            eb = botao && !m_pb;
            eu = desfazer && !m_pu;
            m_pb = botao;
            m_pu = desfazer;
            m_err = 1'b0;
            m_sat = 1'b0;
            p = int'(pontos);
            if (zerar) begin
                m_score[0] = 0; m_score[1] = 0;
                m_hv = 1'b0;
            end else if (eu) begin
                if (m_hv) begin
                    m_score[m_heq] = m_hs;
                    m_hv = 1'b0;
                end
            end else if (eb && p != 0 && int'(equipe) < 2) begin
                s = m_score[equipe];
                if (!chavePN) begin
                    m_sat = (s + p > MAXP);
                    m_score[equipe] = (s + p > MAXP) ? MAXP : s + p;
                    m_heq = int'(equipe); m_hs = s; m_hv = 1'b1;
                end else if (s < p) begin
                    m_err = 1'b1;
                end else begin
                    m_score[equipe] = s - p;
                    m_heq = int'(equipe); m_hs = s; m_hv = 1'b1;
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            total += 4;
            if (int'(placar[6:0]) != m_score[0] || int'(placar[13:7]) != m_score[1]) begin
                bad++;
                $display("FAIL model placar t=%0t got=%0d/%0d exp=%0d/%0d", $time,
                         placar[13:7], placar[6:0], m_score[1], m_score[0]);
            end
            if (erro_sub != m_err) begin
                bad++;
                $display("FAIL model erro_sub t=%0t got=%0b exp=%0b", $time, erro_sub, m_err);
            end
            if (saturou != m_sat) begin
                bad++;
                $display("FAIL model saturou t=%0t got=%0b exp=%0b", $time, saturou, m_sat);
            end
            if (desfazer_ok != m_hv) begin
                bad++;
                $display("FAIL model desfazer_ok t=%0t got=%0b exp=%0b", $time, desfazer_ok, m_hv);
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic press(input int eq, input int p, input bit sub, output bit e, output bit s);
        equipe = 1'(eq); pontos = 2'(p); chavePN = sub; botao = 1'b1;
        cyc();
        e = erro_sub; s = saturou;
        botao = 1'b0;
        cyc();
    endtask

    task automatic undo();
        desfazer = 1'b1;
        cyc();
        desfazer = 1'b0;
        cyc();
    endtask

    initial begin
        bit e;
        bit s;
        total = 0; bad = 0;
        rst_n = 1'b0; botao = 1'b0; desfazer = 1'b0; zerar = 1'b0;
        equipe = 1'b0; pontos = 2'd0; chavePN = 1'b0;
        repeat (3) cyc();
        chk("reset_placar", int'(placar), 0);
        chk("reset_ok", int'(desfazer_ok), 0);
        rst_n = 1'b1;
        cyc();

        // 1: three +3 events on team 0
        repeat (3) press(0, 3, 1'b0, e, s);
        chk("t1_team0", int'(placar[6:0]), 9);
        chk("t1_ok", int'(desfazer_ok), 1);
        chk("t1_flags", int'({erro_sub, saturou}), 0);

        // 2: underflow blocked, then exact subtract to zero
        press(1, 2, 1'b0, e, s);
        press(1, 3, 1'b1, e, s);
        chk("t2_err_pulse", int'(e), 1);
        chk("t2_err_cleared", int'(erro_sub), 0);
        chk("t2_team1_kept", int'(placar[13:7]), 2);
        press(1, 2, 1'b1, e, s);
        chk("t2_sub_noerr", int'(e), 0);
        chk("t2_team1_zero", int'(placar[13:7]), 0);

        // 3: saturation at the ceiling
        repeat (29) press(0, 3, 1'b0, e, s);
        press(0, 2, 1'b0, e, s);
        chk("t3_team0_98", int'(placar[6:0]), 98);
        press(0, 3, 1'b0, e, s);
        chk("t3_sat_pulse", int'(s), 1);
        chk("t3_team0_99", int'(placar[6:0]), 99);
        chk("t3_sat_cleared", int'(saturou), 0);
        press(0, 1, 1'b0, e, s);
        chk("t3_sat_again", int'(s), 1);
        chk("t3_team0_still99", int'(placar[6:0]), 99);

        // 4: undo restores once, second undo is ignored
        zerar = 1'b1; cyc(); zerar = 1'b0; cyc();
        chk("t4_zerar", int'(placar), 0);
        chk("t4_zerar_ok", int'(desfazer_ok), 0);
        repeat (3) press(0, 3, 1'b0, e, s);
        press(0, 1, 1'b0, e, s);
        press(0, 3, 1'b0, e, s);
        chk("t4_team0_13", int'(placar[6:0]), 13);
        undo();
        chk("t4_undo_10", int'(placar[6:0]), 10);
        chk("t4_undo_ok0", int'(desfazer_ok), 0);
        undo();
        chk("t4_undo2_10", int'(placar[6:0]), 10);

        // 5: held button gives one event; undo wins over a simultaneous command
        equipe = 1'b1; pontos = 2'd2; chavePN = 1'b0; botao = 1'b1;
        repeat (20) cyc();
        botao = 1'b0; cyc();
        chk("t5_held_once", int'(placar[13:7]), 2);
        equipe = 1'b1; pontos = 2'd3; botao = 1'b1; desfazer = 1'b1;
        cyc();
        chk("t5_undo_only_t1", int'(placar[13:7]), 0);
        chk("t5_undo_only_t0", int'(placar[6:0]), 10);
        chk("t5_undo_ok0", int'(desfazer_ok), 0);
        botao = 1'b0; desfazer = 1'b0; cyc();

        // 6: button held through reset release, then zerar beats a command
        equipe = 1'b0; pontos = 2'd3; chavePN = 1'b0; botao = 1'b1;
        rst_n = 1'b0; repeat (2) cyc();
        rst_n = 1'b1; repeat (3) cyc();
        chk("t6_no_fire", int'(placar), 0);
        botao = 1'b0; cyc();
        press(0, 3, 1'b0, e, s);
        chk("t6_team0_3", int'(placar[6:0]), 3);
        zerar = 1'b1; botao = 1'b1; cyc();
        chk("t6_zerar_wins", int'(placar), 0);
        chk("t6_zerar_ok", int'(desfazer_ok), 0);
        zerar = 1'b0; botao = 1'b0; cyc();

        // Randomized traffic; the per-cycle compare process does the checking.
        for (int i = 0; i < 3000; i++) begin
            botao    = ($urandom_range(0, 2) == 0);
            desfazer = ($urandom_range(0, 9) == 0);
            zerar    = ($urandom_range(0, 150) == 0);
            equipe   = 1'($urandom_range(0, 1));
            pontos   = 2'($urandom_range(0, 3));
            chavePN  = ($urandom_range(0, 9) < 3);
            rst_n    = ($urandom_range(0, 400) != 0);
            cyc();
        end
        rst_n = 1'b1; botao = 1'b0; desfazer = 1'b0; zerar = 1'b0;
        repeat (2) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
